instr_fetch_stage: RTL
======================

Name: instr_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register. Sits directly upstream of the control unit.
- Holds the PC and issues one request at a time to instruction memory, which has variable latency.
- Registers each returned 16-bit instruction and presents its 3-bit opcode field to the control unit.
- Supports decode stall and branch redirect/flush.

Parameters:
ADDR_W, 16, PC/instruction-memory address width (word addressed)
INSTR_W, 16, instruction width; opcode = instr[INSTR_W-1 -: 3]
RESET_PC, 0, PC value loaded on reset

Ports:
inp_clk  input  1  clock, rising edge
inp_resetN  input  1  synchronous active-low reset
out_imemReq  output  1  request strobe to instruction memory, one cycle per request
out_imemAddr  output  ADDR_W  request address, held stable while waiting for response
inp_imemValid  input  1  response valid, one-cycle pulse, at least 1 cycle after out_imemReq
inp_imemData  input  INSTR_W  response instruction, qualified by inp_imemValid
inp_stall  input  1  decode stage cannot accept; IF/ID contents must hold
inp_branchTaken  input  1  one-cycle redirect pulse from branch resolution
inp_branchTarget  input  ADDR_W  redirect PC, qualified by inp_branchTaken
out_valid  output  1  IF/ID register holds a live instruction
out_instr  output  INSTR_W  IF/ID instruction
out_opCode  output  3  out_instr[INSTR_W-1 -: 3], drives the control unit opcode input
out_pcPlus1  output  ADDR_W  PC of out_instr plus 1, for branch target add

Behaviour:
- Reset (inp_resetN=0 at clock edge):
  - pc=RESET_PC; state=FETCH.
  - out_valid=0; out_instr=0; out_pcPlus1=0; out_imemReq=0.
  - Any discard flag is cleared; an in-flight response is abandoned. A stray valid in the first post-reset cycle is ignored because state is FETCH.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - out_imemReq=1 and out_imemAddr=pc for exactly this cycle; next state is WAIT.
- WAIT:
  - out_imemReq=0; out_imemAddr held at pc.
  - On inp_imemValid with discard=1: drop the data, clear discard, go to FETCH.
  - On inp_imemValid with inp_stall=0: load IF/ID (instr, pc+1, out_valid=1), pc<=pc+1, go to FETCH.
  - On inp_imemValid with inp_stall=1: capture data into the skid register, go to HOLD. IF/ID is unchanged.
- HOLD:
  - When inp_stall=0: move the skid register into IF/ID, pc<=pc+1, go to FETCH.
- Stall while not receiving: IF/ID holds all outputs. The fetch FSM may still issue a request.
- Branch (inp_branchTaken=1) has priority over stall and over a response in the same cycle:
  - pc<=inp_branchTarget; out_valid<=0 (flush IF/ID); skid register invalidated.
  - In WAIT with no valid this cycle: set discard=1, stay in WAIT.
  - Otherwise: go to FETCH; a same-cycle response is dropped.
- Latency: request to out_valid is memory latency + 1 cycle. Throughput is at most 1 instruction per 2 cycles with a 1-cycle memory.
- PC arithmetic is modulo 2^ADDR_W; wrap from all-ones to 0 is silent.

Optional Feature:
- Macro FETCH_PREDECODE_EN.
- Defined: adds output out_isBranch (1 bit), registered alongside IF/ID and equal to (opcode==3'b110). Cleared on reset and flush.
- Also: when a captured instruction is a branch, the stage does not issue the next fetch until the branch is resolved (inp_branchTaken pulse or inp_stall falling edge after capture). This avoids wasted requests.
- Undefined: port absent; fetch continues sequentially.

Decomposition:
- Shared package (cpu_pkg) holds:
  - opcode constants OP_RTYPE=0 … OP_BRANCH=6, OP_7=7;
  - opcode field position/width;
  - fetch FSM state encoding (2-bit);
  - RESET_PC default.
- One sub-module, if_id_reg: the IF/ID register with hold (stall), flush (branch) and load controls, plus the skid slot.
- FSM and PC logic stay in the top module.

Test Plan:
- Reset then 1-cycle memory with imem[0]=16'h2123, imem[1]=16'hC005 -> out_valid at cycle 3 with out_opCode=1, out_pcPlus1=1; next instruction has out_opCode=6, out_pcPlus1=2.
- Response arrives while inp_stall=1 for 3 cycles -> IF/ID unchanged, no new out_imemReq; on release the captured instruction appears 1 cycle later, in order, with none lost.
- inp_branchTaken with target 16'h0040 while in WAIT, data returns 2 cycles later -> data dropped, out_valid=0, next out_imemAddr=16'h0040.
- inp_branchTaken in the same cycle as inp_imemValid and inp_stall=1 -> branch wins: pc=target, out_valid=0, skid empty.
- pc=16'hFFFF, instruction fetched -> next out_imemAddr=16'h0000.
- inp_resetN=0 while in HOLD -> next cycle out_valid=0, out_imemReq=0; then FETCH at RESET_PC. With FETCH_PREDECODE_EN, an opcode 6 instruction gives out_isBranch=1 and no further request until it resolves.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode map, opcode field geometry and fetch FSM encoding.
package cpu_pkg;

    // The opcode occupies the top OPC_W bits of every instruction word.
    localparam int OPC_W = 3;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_RTYPE  = 3'd0;
    localparam opcode_t OP_ITYPE  = 3'd1;
    localparam opcode_t OP_LOAD   = 3'd2;
    localparam opcode_t OP_STORE  = 3'd3;
    localparam opcode_t OP_JUMP   = 3'd4;
    localparam opcode_t OP_JAL    = 3'd5;
    localparam opcode_t OP_BRANCH = 3'd6;
    localparam opcode_t OP_7      = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    function automatic logic is_branch_op(input opcode_t op);
        return op == OP_BRANCH;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load/hold/flush and a one-entry skid slot for
// responses that arrive while decode is stalled. FETCH_PREDECODE_EN adds is_branch.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_new,
    input  logic               load_skid,
    input  logic               capture,
    input  logic               flush,
    input  logic               stall,
    input  logic [INSTR_W-1:0] new_instr,
    input  logic [ADDR_W-1:0]  pc_plus1,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc_plus1
`ifdef FETCH_PREDECODE_EN
    ,
    output logic               is_branch,
    output logic [INSTR_W-1:0] skid_instr
`endif
);

    logic [INSTR_W-1:0] skid;

    // When decode accepts and nothing new arrives, a bubble is inserted so the
    // same instruction is never presented twice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid          <= 1'b0;
            instr          <= '0;
            instr_pc_plus1 <= '0;
`ifdef FETCH_PREDECODE_EN
            is_branch      <= 1'b0;
`endif
        end else if (flush) begin
            valid          <= 1'b0;
`ifdef FETCH_PREDECODE_EN
            is_branch      <= 1'b0;
`endif
        end else if (load_new) begin
            valid          <= 1'b1;
            instr          <= new_instr;
            instr_pc_plus1 <= pc_plus1;
`ifdef FETCH_PREDECODE_EN
            is_branch      <= is_branch_op(new_instr[INSTR_W-1 -: OPC_W]);
`endif
        end else if (load_skid) begin
            valid          <= 1'b1;
            instr          <= skid;
            instr_pc_plus1 <= pc_plus1;
`ifdef FETCH_PREDECODE_EN
            is_branch      <= is_branch_op(skid[INSTR_W-1 -: OPC_W]);
`endif
        end else if (!stall) begin
            valid          <= 1'b0;
`ifdef FETCH_PREDECODE_EN
            is_branch      <= 1'b0;
`endif
        end
    end

    // Skid occupancy is implied by the fetch FSM being in HOLD.
    always_ff @(posedge clk) begin
        if (capture) begin
            skid <= new_instr;
        end
    end

`ifdef FETCH_PREDECODE_EN
    assign skid_instr = skid;
`endif

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, single-outstanding-request fetch FSM and IF/ID register.
// FETCH_PREDECODE_EN adds out_isBranch and suspends fetching behind a captured branch.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               inp_clk,
    input  logic               inp_resetN,
    output logic               out_imemReq,
    output logic [ADDR_W-1:0]  out_imemAddr,
    input  logic               inp_imemValid,
    input  logic [INSTR_W-1:0] inp_imemData,
    input  logic               inp_stall,
    input  logic               inp_branchTaken,
    input  logic [ADDR_W-1:0]  inp_branchTarget,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [OPC_W-1:0]   out_opCode,
    output logic [ADDR_W-1:0]  out_pcPlus1
`ifdef FETCH_PREDECODE_EN
    ,
    output logic               out_isBranch
`endif
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, pc_inc;
    logic              discard, discard_nxt;
    logic              req, load_new, load_skid, capture, flush;
    logic              fetch_gate;

`ifdef FETCH_PREDECODE_EN
    logic               bwait, bwait_nxt, stall_q;
    logic [INSTR_W-1:0] skid_instr;
    assign fetch_gate = !bwait;
`else
    assign fetch_gate = 1'b1;
`endif

    assign pc_inc = pc + ADDR_W'(1);

    always_ff @(posedge inp_clk) begin
        if (!inp_resetN) begin
            state   <= ST_FETCH;
            pc      <= RESET_PC;
            discard <= 1'b0;
`ifdef FETCH_PREDECODE_EN
            bwait   <= 1'b0;
            stall_q <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            discard <= discard_nxt;
`ifdef FETCH_PREDECODE_EN
            bwait   <= bwait_nxt;
            stall_q <= inp_stall;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        discard_nxt = discard;
        req         = 1'b0;
        load_new    = 1'b0;
        load_skid   = 1'b0;
        capture     = 1'b0;
        flush       = 1'b0;

        case (state)
            ST_FETCH: begin
                if (fetch_gate) begin
                    req       = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (inp_imemValid) begin
                    if (discard) begin
                        discard_nxt = 1'b0;
                        state_nxt   = ST_FETCH;
                    end else if (!inp_stall) begin
                        load_new  = 1'b1;
                        pc_nxt    = pc_inc;
                        state_nxt = ST_FETCH;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!inp_stall) begin
                    load_skid = 1'b1;
                    pc_nxt    = pc_inc;
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase

        // A redirect overrides everything; a request still in flight must have
        // its response swallowed, so WAIT stays put with discard armed.
        if (inp_branchTaken) begin
            pc_nxt    = inp_branchTarget;
            flush     = 1'b1;
            load_new  = 1'b0;
            load_skid = 1'b0;
            capture   = 1'b0;
            if (state == ST_WAIT && !inp_imemValid) begin
                discard_nxt = 1'b1;
                state_nxt   = ST_WAIT;
            end else begin
                discard_nxt = 1'b0;
                state_nxt   = ST_FETCH;
            end
        end

`ifdef FETCH_PREDECODE_EN
        bwait_nxt = bwait;
        if ((load_new && is_branch_op(inp_imemData[INSTR_W-1 -: OPC_W])) ||
            (load_skid && is_branch_op(skid_instr[INSTR_W-1 -: OPC_W]))) begin
            bwait_nxt = 1'b1;
        end else if (stall_q && !inp_stall) begin
            bwait_nxt = 1'b0;
        end
        if (inp_branchTaken) begin
            bwait_nxt = 1'b0;
        end
`endif
    end

    assign out_imemReq  = req && inp_resetN;
    assign out_imemAddr = pc;

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk            (inp_clk),
        .rst_n          (inp_resetN),
        .load_new       (load_new),
        .load_skid      (load_skid),
        .capture        (capture),
        .flush          (flush),
        .stall          (inp_stall),
        .new_instr      (inp_imemData),
        .pc_plus1       (pc_inc),
        .valid          (out_valid),
        .instr          (out_instr),
        .instr_pc_plus1 (out_pcPlus1)
`ifdef FETCH_PREDECODE_EN
        ,
        .is_branch      (out_isBranch),
        .skid_instr     (skid_instr)
`endif
    );

    assign out_opCode = out_instr[INSTR_W-1 -: OPC_W];

endmodule
